// File: rtl/csa_resolve_pkg.sv
// Shared types and constants for the redundant-pair resolve stage.
package csa_resolve_pkg;

  // Defaults shared with the squaring compressor tree.
  localparam int CSA_WIDTH = 64;
  localparam int CSA_SEG_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Segments needed to cover the WIDTH+2 result bits.
  function automatic int num_seg(input int width, input int seg_w);
    return (width + 2 + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/csa_seg_add.sv
// One SEG_W-bit slice of the carry-propagate add, carry in and carry out.
module csa_seg_add #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             ci_i,
  output logic [SEG_W-1:0] s_o,
  output logic             co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, ci_i};

endmodule

// File: rtl/csa_resolve_seq.sv
// Resolves a (sum, carry) redundant pair to binary, one segment per cycle.
module csa_resolve_seq
  import csa_resolve_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int SEG_W = CSA_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_data,
  output logic             busy
);

  localparam int NUM_SEG = num_seg(WIDTH, SEG_W);
  localparam int OP_W    = NUM_SEG * SEG_W;
  localparam int RES_W   = WIDTH + 2;
  localparam int CNT_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 seg_cnt_q, seg_cnt_d;
  logic                             cy_q, cy_d;
  logic [NUM_SEG-1:0][SEG_W-1:0]    a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]                 res_q, res_d;
  logic                             wr_en;
  logic [SEG_W-1:0]                 seg_sum;
  logic                             seg_co;

  // Single shared slice adder; operands are muxed by the segment counter.
  csa_seg_add #(.SEG_W(SEG_W)) u_seg_add (
    .a_i  (a_q[seg_cnt_q]),
    .b_i  (b_q[seg_cnt_q]),
    .ci_i (cy_q),
    .s_o  (seg_sum),
    .co_o (seg_co)
  );

  // Result write-back per segment; the top segment is clipped to RES_W so
  // the always-zero pad bits are never stored.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    localparam int LO  = k * SEG_W;
    localparam int LEN = ((k + 1) * SEG_W > RES_W) ? (RES_W - LO) : SEG_W;
    assign res_d[LO +: LEN] = (wr_en && seg_cnt_q == CNT_W'(k)) ? seg_sum[LEN-1:0]
                                                                : res_q[LO +: LEN];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    cy_d      = cy_q;
    a_d       = a_q;
    b_d       = b_q;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = OP_W'(in_sum);
          b_d       = OP_W'({in_carry, 1'b0});
          seg_cnt_d = '0;
          cy_d      = 1'b0;
          state_d   = ADD;
        end
      end
      ADD: begin
        wr_en     = 1'b1;
        cy_d      = seg_co;
        seg_cnt_d = seg_cnt_q + CNT_W'(1);
        if (seg_cnt_q == LAST_SEG) begin
          // Final carry is always zero for in-range operands.
          seg_cnt_d = '0;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seg_cnt_q <= '0;
      cy_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      cy_q      <= cy_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Scoreboard bench for csa_resolve_seq at WIDTH=64, SEG_W=16.
module tb_csa_resolve_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_sum = '0;
  logic [63:0] in_carry = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [65:0] out_data;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [65:0] sb_q[$];

  csa_resolve_seq #(.WIDTH(64), .SEG_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] model(input logic [63:0] s, input logic [63:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a pair, wait (bounded) for acceptance, record expected result.
  task automatic send(input logic [63:0] s, input logic [63:0] c);
    int n = 0;
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    sb_q.push_back(model(s, c));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, busy, in_ready} !== {1'b0, 66'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b ready=%b required 0/0/0/1",
               out_valid, out_data, busy, in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_simple;
    int n;
    logic [65:0] exp;
    out_ready = 1'b1;
    send(64'h1, 64'h1);
    wait_valid(n);
    checks++;
    if (n !== 5 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL simple_latency: cycles=%0d valid=%b required 5/1", n, out_valid);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 66'hx;
    checks++;
    if (out_data !== exp) begin
      failures++;
      $display("FAIL simple_data: got %h required %h", out_data, exp);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simple_handshake: valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_patterns;
    logic [63:0] ts[4];
    logic [63:0] tc[4];
    int n;
    logic [65:0] exp;
    ts[0] = 64'hFFFF;               tc[0] = 64'h1;
    ts[1] = 64'hFFFF_FFFF_FFFF_FFFF; tc[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    ts[2] = 64'h8000_0000_0000_0000; tc[2] = 64'h8000_0000_0000_0000;
    ts[3] = 64'h0123_4567_89AB_CDEF; tc[3] = 64'h7FFF_0000_FFFF_8001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ts[i], tc[i]);
      wait_valid(n);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 66'hx;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        failures++;
        $display("FAIL pattern%0d: valid=%b data=%h required 1/%h", i, out_valid, out_data, exp);
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [65:0] held, exp;
    int bad = 0;
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    wait_valid(n);
    held = out_data;
    in_sum   = 64'hAAAA_0000_5555_0000;
    in_carry = 64'h0000_3333_0000_CCCC;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d unstable cycles, valid=%b ready=%b required 0 unstable", bad, out_valid, in_ready);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 66'hx;
    checks++;
    if (held !== exp) begin
      failures++;
      $display("FAIL bp_data: got %h required %h", held, exp);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    sb_q.push_back(model(in_sum, in_carry));
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept: busy=%b required 1", busy);
    end
    wait_valid(n);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 66'hx;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      failures++;
      $display("FAIL bp_second: valid=%b data=%h required 1/%h", out_valid, out_data, exp);
    end
    step();
  endtask

  task automatic test_reset_mid;
    int n;
    logic [65:0] exp;
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, busy, in_ready} !== {1'b0, 66'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_state: valid=%b data=%h busy=%b ready=%b required 0/0/0/1",
               out_valid, out_data, busy, in_ready);
    end
    sb_q.delete();
    #3 rst_n = 1'b1;
    step();
    send(64'h5, 64'h2);
    wait_valid(n);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 66'hx;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      failures++;
      $display("FAIL midreset_fresh: valid=%b data=%h required 1/%h", out_valid, out_data, exp);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int last_acc = -1;
    int accs = 0;
    int gap_bad = 0;
    int data_bad = 0;
    int budget = 0;
    logic acc;
    logic [65:0] exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 64'h100;
    in_carry  = 64'h33;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = in_valid && in_ready;
      if (acc) begin
        sb_q.push_back(model(in_sum, in_carry));
        if (last_acc >= 0 && cyc - last_acc != 7) gap_bad++;
        last_acc = cyc;
        accs++;
      end
      if (out_valid && out_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 66'hx;
        if (out_data !== exp) data_bad++;
      end
      step();
      if (acc) in_sum = in_sum + 64'd1;
    end
    in_valid = 1'b0;
    while (sb_q.size() > 0 && budget < 20) begin
      if (out_valid) begin
        exp = sb_q.pop_front();
        if (out_data !== exp) data_bad++;
      end
      step();
      budget++;
    end
    checks++;
    if (gap_bad != 0 || accs < 8) begin
      failures++;
      $display("FAIL b2b_period: accepts=%0d bad_gaps=%0d required >=8/0", accs, gap_bad);
    end
    checks++;
    if (data_bad != 0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_data: bad=%0d leftover=%0d required 0/0", data_bad, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_resolve_seq.md
Name: csa_resolve_seq

Overview:
- Stage directly downstream of the 3:2 compressor layers of the squaring compressor tree.
- Consumes the final redundant pair (sum vector, carry vector) and resolves it to a binary word.
- Uses a multi-cycle, segment-serial carry-propagate add, so no full-width adder sits in a single cycle.
- valid/ready on both sides; feeds the modular-reduction stage.

Parameters:
- WIDTH, 64: width of in_sum and in_carry.
- SEG_W, 16: bits added per cycle.
- NUM_SEG, ceil((WIDTH+2)/SEG_W) = 5: number of segments. Derived; do not override.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  redundant pair present
- in_ready  output  1  block can accept a pair
- in_sum  input  WIDTH  sum vector; bit i has weight 2^i
- in_carry  input  WIDTH  carry vector; bit i has weight 2^(i+1)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH+2  in_sum + 2*in_carry
- busy  output  1  state != IDLE

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. Reset forces:
  - state=IDLE, seg_cnt=0, carry flop=0
  - out_valid=0, out_data=0, busy=0, in_ready=1
- Operand widths:
  - Internal operands are OP_W = NUM_SEG*SEG_W bits.
  - a = zero-extended in_sum.
  - b = zero-extended {in_carry, 1'b0}.
  - Pad bits above WIDTH+2 are always 0 and are dropped from out_data.
- FSM states: IDLE, ADD, OUT.
- in_ready = (state==IDLE). It is a registered-state decode, with no combinational path from out_ready.
- IDLE:
  - On in_valid, capture a and b, clear seg_cnt and the carry flop, go to ADD.
  - in_valid alone never changes outputs.
- ADD, each cycle:
  - {cy, r_seg} = a[seg_cnt] + b[seg_cnt] + cy, computed SEG_W bits wide.
  - r_seg is written into out_data segment seg_cnt.
  - seg_cnt increments.
  - After segment NUM_SEG-1 is written: go to OUT and set out_valid=1.
  - The final cy is provably 0 and is not observed.
- OUT:
  - out_valid=1 and out_data held stable until out_ready=1.
  - On that edge: out_valid=0, go to IDLE.
- Latency and throughput:
  - Acceptance edge T0; out_valid rises after edge T0+NUM_SEG (5 for the defaults).
  - Minimum period between acceptances is NUM_SEG+2 cycles (7).
- Boundary cases:
  - in_valid while ADD/OUT: ignored, because in_ready=0. Upstream must hold.
  - out_ready high outside OUT: no effect.
  - rst_n low mid-ADD or mid-OUT: the operation is aborted and all outputs take their reset values immediately. No partial result is emitted.
  - out_data is defined only while out_valid=1. In ADD it changes segment by segment.
  - Max input (all ones on both vectors) gives 3*2^WIDTH-3, which fits in WIDTH+2 bits.

Decomposition:
- Package csa_resolve_pkg:
  - state encoding (IDLE=2'd0, ADD=2'd1, OUT=2'd2)
  - function for NUM_SEG (ceil divide)
  - default WIDTH/SEG_W constants shared with the compressor tree
- Sub-module csa_seg_add: SEG_W-bit adder with carry-in/carry-out, purely combinational. Instantiated once and muxed by seg_cnt.

Test Plan (WIDTH=64, SEG_W=16):
- Simple add: in_sum=0x1, in_carry=0x1, out_ready=1.
  - out_valid exactly 5 cycles after acceptance.
  - out_data=0x3.
- Cross-segment ripple: in_sum=0xFFFF, in_carry=0x1.
  - out_data=0x1_0001, which requires carry from seg0 into seg1.
- Maximum operands: in_sum=in_carry=0xFFFF_FFFF_FFFF_FFFF.
  - out_data=0x2_FFFF_FFFF_FFFF_FFFD.
- Backpressure: result ready, out_ready=0 for 10 cycles, in_valid=1 with new data.
  - out_valid and out_data stable throughout, in_ready=0, new data not captured.
  - Release out_ready: handshake, then IDLE, then new pair accepted.
- Reset mid-operation: assert rst_n=0 asynchronously 2 cycles into ADD.
  - Immediately out_valid=0, out_data=0, busy=0, in_ready=1.
  - After release, a fresh pair 0x5/0x2 yields 0x9.
- Back-to-back throughput: in_valid=1 and out_ready=1 held constantly with an incrementing in_sum.
  - Acceptances every 7 cycles.
  - Every result equals the scoreboard value sum+2*carry.
